// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx
//   Receive half of the UART link. Samples the serial line at the bit centre,
//   deserialises one 8N1 frame (start, 8 data bits LSB first, stop) and
//   presents the byte with a one-cycle strobe. Defaults match uart_tx,
//   including its inverted payload polarity on the wire.
//
// Ports
//   clk        system clock (single domain)
//   rst        asynchronous, active-low reset
//   rx         serial line, asynchronous to clk, idles high
//   rx_data    last good byte, held until the next good frame
//   rx_valid   one-cycle pulse: good frame completed, rx_data is new
//   frame_err  one-cycle pulse: stop bit sampled low
//   busy       high whenever the receiver is not idle
module uart_rx #(
  parameter int BAUD_RATE   = 115_200,
  parameter int CLOCK_SPEED = 50_000_000,
  parameter int BAUD_WIDTH  = int'(CLOCK_SPEED / BAUD_RATE),
  parameter int HALF_WIDTH  = BAUD_WIDTH / 2,
  parameter bit INVERT_DATA = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(BAUD_WIDTH);
  localparam logic [CNT_W-1:0] CNT_BAUD_LAST = CNT_W'(BAUD_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_WIDTH - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rx_meta;
  logic             rx_s;
  logic             rx_d;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       sh;

  logic             cnt_run;
  logic             cnt_clr;
  logic             shift_en;
  logic             bit_clr;
  logic             bit_inc;
  logic             load_byte;
  logic             ferr_set;

  // Two-flop synchroniser plus one history flop for edge detection. All
  // reset to the idle line level so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // Only a high-to-low transition starts a frame; a line stuck low is ignored.
  assign fall = rx_d & ~rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_run   = 1'b0;
    shift_en  = 1'b0;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    load_byte = 1'b0;
    ferr_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = START;
        end
      end
      START: begin
        cnt_run = 1'b1;
        if (cnt == CNT_HALF_LAST) begin
          if (!rx_s) begin
            state_nxt = DATA;
            bit_clr   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        cnt_run = 1'b1;
        if (cnt == CNT_BAUD_LAST) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      STOP: begin
        cnt_run = 1'b1;
        // Leaving at the stop-bit centre leaves half a bit to catch a
        // back-to-back start edge.
        if (cnt == CNT_BAUD_LAST) begin
          state_nxt = IDLE;
          if (rx_s) begin
            load_byte = 1'b1;
          end else begin
            ferr_set = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign cnt_clr = (state_nxt != state) || shift_en || !cnt_run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_idx <= '0;
    end else if (bit_clr) begin
      bit_idx <= '0;
    end else if (bit_inc) begin
      bit_idx <= bit_idx + 1'b1;
    end
  end

  // Right shift with the newest bit entering at the MSB: after eight
  // samples the first-received bit sits at sh[0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh <= '0;
    end else if (shift_en) begin
      sh <= {rx_s, sh[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= load_byte;
      frame_err <= ferr_set;
      if (load_byte) begin
        rx_data <= INVERT_DATA ? ~sh : sh;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx
//   Drives serial frames into uart_rx and checks every cycle against a
//   frame-level model: each frame sent defines a time window, the pulse it
//   must produce (if any), the decoded byte, and when busy must be high/low.
module tb_uart_rx;

  localparam int unsigned BW  = 434;
  localparam int unsigned LAT = 4126;   // start edge on rx -> strobe
  localparam int unsigned FS  = 220;    // start edge on rx -> false-start abort
  localparam bit          INV = 1'b1;
  localparam int K_GOOD  = 0;
  localparam int K_FERR  = 1;
  localparam int K_FALSE = 2;

  typedef struct {
    int unsigned s;
    int unsigned e;
    int          kind;
    logic [7:0]  exp;
    bit          seen;
  } win_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;
  win_t        wq[$];
  logic [7:0]  last_good = 8'h00;
  int unsigned valid_cnt = 0;
  int unsigned ferr_cnt  = 0;
  int unsigned vcyc[$];
  logic [7:0]  vdat[$];
  int unsigned exp_valid_total = 0;
  int unsigned exp_ferr_total  = 0;

  uart_rx #(
    .BAUD_RATE  (115_200),
    .CLOCK_SPEED(50_000_000),
    .INVERT_DATA(INV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input bit ok, input string name,
                     input int unsigned act, input int unsigned exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] decode(input logic [7:0] w);
    return INV ? ~w : w;
  endfunction

  // Per-cycle compare against the frame-window model.
  always @(negedge clk) begin
    bit ok_w;
    bit want1;
    bit want0;
    cyc++;
    if (!rst) begin
      chk(rx_data == 8'h00 && !rx_valid && !frame_err && !busy, "reset_outputs",
          {21'd0, rx_data, rx_valid, frame_err, busy}, 0);
      last_good = 8'h00;
      wq.delete();
    end else begin
      while (wq.size() > 0 && cyc > wq[0].e + 3) begin
        if (wq[0].kind != K_FALSE) chk(wq[0].seen, "missing_pulse", 0, 1);
        void'(wq.pop_front());
      end
      chk(!(rx_valid && frame_err), "pulse_exclusive", {rx_valid, frame_err}, 0);
      if (rx_valid) begin
        valid_cnt++;
        vcyc.push_back(cyc);
        vdat.push_back(rx_data);
      end
      if (frame_err) ferr_cnt++;
      if (rx_valid || frame_err) begin
        ok_w = (wq.size() > 0) && (wq[0].kind != K_FALSE) && !wq[0].seen;
        chk(ok_w, "unexpected_pulse", {rx_valid, frame_err}, 0);
        if (ok_w) begin
          chk(cyc + 2 >= wq[0].e && cyc <= wq[0].e + 2, "pulse_time", cyc, wq[0].e);
          chk(rx_valid == (wq[0].kind == K_GOOD), "pulse_kind", rx_valid,
              (wq[0].kind == K_GOOD) ? 1 : 0);
          if (rx_valid) chk(rx_data == wq[0].exp, "rx_data_new", rx_data, wq[0].exp);
          wq[0].seen = 1'b1;
          if (wq[0].kind == K_GOOD) last_good = wq[0].exp;
        end
      end else if (cyc % 128 == 0) begin
        chk(rx_data == last_good, "rx_data_hold", rx_data, last_good);
      end
      if (cyc % 16 == 0) begin
        want1 = 1'b0;
        want0 = 1'b1;
        foreach (wq[i]) begin
          if (cyc >= wq[i].s + 6 && cyc + 3 <= wq[i].e) want1 = 1'b1;
          if (cyc + 1 >= wq[i].s && cyc <= wq[i].e + 3) want0 = 1'b0;
        end
        if (want1) chk(busy == 1'b1, "busy_in_frame", busy, 1);
        if (want0) chk(busy == 1'b0, "busy_idle", busy, 0);
      end
    end
  end

  // All driver tasks start and end just after a rising edge.
  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] wb, input bit stop, input int unsigned bw,
                            output int unsigned s);
    win_t w;
    rx     = 1'b0;
    s      = cyc + 1;
    w.s    = s;
    w.e    = s + LAT;
    w.kind = stop ? K_GOOD : K_FERR;
    w.exp  = decode(wb);
    w.seen = 1'b0;
    wq.push_back(w);
    if (stop) exp_valid_total++;
    else      exp_ferr_total++;
    for (int i = 0; i < 8; i++) begin
      idle(bw);
      rx = wb[i];
    end
    idle(bw);
    rx = stop;
    idle(bw);
    rx = 1'b1;
  endtask

  task automatic glitch(input int unsigned len, output int unsigned s);
    win_t w;
    rx     = 1'b0;
    s      = cyc + 1;
    w.s    = s;
    w.e    = s + FS;
    w.kind = K_FALSE;
    w.exp  = 8'h00;
    w.seen = 1'b0;
    wq.push_back(w);
    idle(len);
    rx = 1'b1;
  endtask

  // Frame cut short by reset in the middle of data bit 4.
  task automatic abort_frame(input logic [7:0] wb);
    win_t w;
    rx     = 1'b0;
    w.s    = cyc + 1;
    w.e    = w.s + LAT;
    w.kind = K_FALSE;
    w.exp  = 8'h00;
    w.seen = 1'b0;
    wq.push_back(w);
    for (int i = 0; i < 5; i++) begin
      idle(BW);
      rx = wb[i];
    end
    idle(BW / 2);
    rst = 1'b0;
    rx  = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned s;
    int unsigned s2;
    int unsigned v0;
    int unsigned f0;
    int unsigned r;
    int unsigned gap;
    bit          prev_ferr;
    logic [7:0]  b;

    rst = 1'b0;
    rx  = 1'b1;
    idle(5);
    chk(rx_data == 8'h00 && !rx_valid && !frame_err && !busy, "reset_state",
        {21'd0, rx_data, rx_valid, frame_err, busy}, 0);
    rst = 1'b1;
    idle(20);

    // Good frame, wire 8'hAA -> 8'h55
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hAA, 1'b1, BW, s);
    idle(10);
    chk(rx_data == 8'h55, "good_data", rx_data, 8'h55);
    chk(valid_cnt - v0 == 1, "good_pulses", valid_cnt - v0, 1);
    chk(ferr_cnt == f0, "good_no_ferr", ferr_cnt - f0, 0);
    if (vcyc.size() > 0)
      chk(vcyc[vcyc.size()-1] - s >= 4124 && vcyc[vcyc.size()-1] - s <= 4128,
          "good_latency", vcyc[vcyc.size()-1] - s, 4126);

    // Transmitter-style frame: data 8'hA5 goes out inverted as 8'h5A
    v0 = valid_cnt;
    send_frame(8'h5A, 1'b1, BW, s);
    idle(10);
    chk(rx_data == 8'hA5, "loop_data", rx_data, 8'hA5);
    chk(valid_cnt - v0 == 1, "loop_pulses", valid_cnt - v0, 1);

    // False start: 100-cycle glitch
    v0 = valid_cnt; f0 = ferr_cnt;
    glitch(100, s);
    idle(50);
    chk(busy == 1'b1, "false_busy_mid", busy, 1);
    idle(80);
    chk(busy == 1'b0, "false_busy_end", busy, 0);
    chk(valid_cnt == v0 && ferr_cnt == f0, "false_no_pulse",
        (valid_cnt - v0) + (ferr_cnt - f0), 0);

    // Framing error after a good 8'h00 (-> 8'hFF)
    send_frame(8'h00, 1'b1, BW, s);
    idle(10);
    chk(rx_data == 8'hFF, "pre_ferr_data", rx_data, 8'hFF);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, BW, s);
    idle(10);
    chk(ferr_cnt - f0 == 1, "ferr_pulses", ferr_cnt - f0, 1);
    chk(valid_cnt == v0, "ferr_no_valid", valid_cnt - v0, 0);
    chk(rx_data == 8'hFF, "ferr_data_kept", rx_data, 8'hFF);

    // Back-to-back: wire FF then 00, no idle gap
    v0 = valid_cnt;
    send_frame(8'hFF, 1'b1, BW, s);
    send_frame(8'h00, 1'b1, BW, s2);
    idle(10);
    chk(valid_cnt - v0 == 2, "b2b_pulses", valid_cnt - v0, 2);
    if (vdat.size() >= v0 + 2) begin
      chk(vdat[v0] == 8'h00, "b2b_first", vdat[v0], 8'h00);
      chk(vdat[v0+1] == 8'hFF, "b2b_second", vdat[v0+1], 8'hFF);
      chk(vcyc[v0+1] - vcyc[v0] >= 4338 && vcyc[v0+1] - vcyc[v0] <= 4342,
          "b2b_spacing", vcyc[v0+1] - vcyc[v0], 4340);
    end

    // Reset during data bit 4, then a good frame
    v0 = valid_cnt; f0 = ferr_cnt;
    abort_frame(8'h96);
    idle(20);
    chk(rx_data == 8'h00 && !busy, "rst_mid_outputs", {23'd0, rx_data, busy}, 0);
    rst = 1'b1;
    idle(30);
    chk(valid_cnt == v0 && ferr_cnt == f0, "rst_no_pulse",
        (valid_cnt - v0) + (ferr_cnt - f0), 0);
    send_frame(8'h0F, 1'b1, BW, s);
    idle(10);
    chk(rx_data == 8'hF0, "rst_next_data", rx_data, 8'hF0);

    // Randomised frames, gaps and bit widths (within +-1%)
    prev_ferr = 1'b0;
    for (int n = 0; n < 6; n++) begin
      r   = $urandom_range(0, 9);
      gap = $urandom_range(0, 200);
      if (prev_ferr && gap < 4) gap = 4;
      idle(gap);
      b = 8'($urandom_range(0, 255));
      if (r <= 5) begin
        send_frame(b, 1'b1, $urandom_range(430, 438), s);
        prev_ferr = 1'b0;
      end else if (r <= 7) begin
        send_frame(b, 1'b0, $urandom_range(430, 438), s);
        prev_ferr = 1'b1;
      end else begin
        glitch($urandom_range(10, 150), s);
        idle(240);
        prev_ferr = 1'b0;
      end
    end

    idle(50);
    chk(valid_cnt == exp_valid_total, "total_valid", valid_cnt, exp_valid_total);
    chk(ferr_cnt == exp_ferr_total, "total_ferr", ferr_cnt, exp_ferr_total);
    chk(wq.size() == 0, "model_drained", wq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the UART link. Samples the asynchronous serial line `rx` at the bit centre, deserialises one 8N1 frame (start, 8 data bits LSB first, stop), and presents the byte on `rx_data` with a one-cycle `rx_valid` strobe. It sits opposite `uart_tx` on the same link, and its default parameters match that transmitter, including the inverted payload polarity on the wire.

## Interface
- `BAUD_RATE`, 115_200, line rate in bit/s.
- `CLOCK_SPEED`, 50_000_000, `clk` frequency in Hz.
- `BAUD_WIDTH`, int'(CLOCK_SPEED / BAUD_RATE) = 434, clock cycles per bit.
- `HALF_WIDTH`, BAUD_WIDTH / 2 = 217, cycles from the start-bit edge to the start-bit centre.
- `INVERT_DATA`, 1, when 1 `rx_data` is the bitwise inverse of the sampled payload, matching the transmitter's inverted payload; when 0 there is no inversion.
- `clk`, input, 1, system clock. There is one clock domain.
- `rst`, input, 1, asynchronous, active-low reset.
- `rx`, input, 1, serial line. It is asynchronous to `clk` and idles high.
- `rx_data`, output, 8, last good byte. Holds its value until the next good frame.
- `rx_valid`, output, 1, one-cycle pulse: a good frame has completed and `rx_data` is new.
- `frame_err`, output, 1, one-cycle pulse: the stop bit sampled low.
- `busy`, output, 1, high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser to give `rx_s`. A third flop `rx_d` holds the previous `rx_s` for edge detection. All synchroniser and edge flops reset to 1.
- Counter `cnt` is $clog2(BAUD_WIDTH) bits wide, 9 bits at the defaults. It clears to 0 on every state change.
- Bit index `bit_idx` is 3 bits wide. The shift register `sh` is 8 bits wide and shifts right, inserting each new bit at bit 7, so the data ends up LSB first.
- States are IDLE, START, DATA and STOP, one-hot encoded.
- IDLE:
  - `cnt` is held at 0.
  - A falling edge (`rx_d`=1 and `rx_s`=0) moves the FSM to START.
  - A line held low without an edge, such as a break, is ignored.
- START:
  - `cnt` counts up.
  - At `cnt` == HALF_WIDTH-1 the FSM samples `rx_s`.
  - If the sample is 0, go to DATA with `bit_idx`=0.
  - If the sample is 1, this is a false start: go to IDLE with no output pulse.
- DATA:
  - `cnt` counts up.
  - At `cnt` == BAUD_WIDTH-1 the FSM shifts `rx_s` into `sh` and clears `cnt`.
  - If `bit_idx`==7, go to STOP; otherwise increment `bit_idx`.
- STOP:
  - At `cnt` == BAUD_WIDTH-1 the FSM samples `rx_s` and goes to IDLE.
  - If the sample is 1, on the next edge `rx_data` loads (INVERT_DATA ? ~sh : sh) and `rx_valid` is set to 1.
  - If the sample is 0, `frame_err` is set to 1 and `rx_data` is unchanged.
- Because the FSM returns to IDLE at the stop-bit centre, a back-to-back start bit is caught. The falling edge arrives about 217 cycles later.
- When `rst` is asserted, even mid-frame:
  - the FSM goes immediately to IDLE and all counters clear;
  - `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `busy`=0;
  - the partial frame is discarded and no pulse is produced.
- The first falling edge after `rst` deasserts starts a frame normally.
- `rx_valid` and `frame_err` are never high in the same cycle, and each is high for exactly one cycle.

## Timing
- The synchroniser adds 2 cycles from a change on `rx` to `rx_s`.
- Edge-detect to START takes 1 cycle.
- The start-bit sample falls HALF_WIDTH cycles after entering START.
- Each data bit and the stop bit are sampled BAUD_WIDTH cycles after the previous sample, which is the bit centre.
- `rx_valid` rises 1 cycle after the stop sample, about 2+1+217+9·434 = 4126 cycles (±2) after the start-bit falling edge on `rx`.
- `busy` rises with START and falls in the cycle `rx_valid` or `frame_err` is asserted.
- Sampling error tolerates at least ±2% baud mismatch at the defaults.

## Test plan
- Good frame: drive start, wire payload 8'hAA LSB first, then stop, each bit 434 cycles, with INVERT_DATA=1. Required: `rx_data`=8'h55, one `rx_valid` pulse about 4126 cycles after the start edge, `frame_err` stays 0.
- Loopback: `uart_tx` with data=8'hA5 and `send` pulsed, its `tx` driving `rx`. Required: `rx_data`=8'hA5 and exactly one `rx_valid`.
- False start: a 100-cycle low glitch on an idle line. Required: `busy` returns to 0 about 220 cycles after the glitch, with no `rx_valid` and no `frame_err`.
- Framing error: a good frame carrying 8'h00 first, then a frame with the stop bit driven 0. Required: one `frame_err` pulse, no `rx_valid`, and `rx_data` keeps the previous 8'hFF.
- Back-to-back: two frames with wire payloads 8'hFF then 8'h00 and no idle gap. Required: two `rx_valid` pulses 4340 ±2 cycles apart, with `rx_data`=8'h00 and then 8'hFF.
- Reset mid-frame: assert `rst`=0 during data bit 4, release it, then send a good frame. Required: outputs are 0 during reset, there is no pulse for the aborted frame, and the next frame is received correctly.
